// File: rtl/multi_cam_frame_sync_if.sv
// Stream bundle for the multi-camera frame aligner: N_CH narrow input lanes
// with per-lane handshake, and one wide packed output stream.
interface multi_cam_frame_sync_if #(
  parameter int N_CH   = 2,
  parameter int DATA_W = 32
);
  logic [N_CH*DATA_W-1:0]   s_axis_tdata;
  logic [N_CH-1:0]          s_axis_tvalid;
  logic [N_CH-1:0]          s_axis_tready;
  logic [N_CH-1:0]          s_axis_tuser;
  logic [N_CH-1:0]          s_axis_tlast;

  logic [N_CH*DATA_W-1:0]   m_axis_tdata;
  logic                     m_axis_tvalid;
  logic                     m_axis_tready;
  logic                     m_axis_tuser;
  logic                     m_axis_tlast;
  logic [N_CH*DATA_W/8-1:0] m_axis_tkeep;

  // Aligner side: consumes the camera lanes, produces the packed stream.
  modport slave (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tuser, s_axis_tlast, m_axis_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tuser, m_axis_tlast,
    m_axis_tkeep
  );

  // Environment side: drives the cameras, sinks the packed stream.
  modport master (
    output s_axis_tdata, s_axis_tvalid, s_axis_tuser, s_axis_tlast, m_axis_tready,
    input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tuser, m_axis_tlast,
    m_axis_tkeep
  );
endinterface

// File: rtl/multi_cam_frame_sync.sv
// Buffers N_CH camera streams in per-lane FWFT FIFOs, locks all heads onto a
// common start-of-frame and emits matched pixels side-by-side on one stream.
module multi_cam_frame_sync #(
  parameter int N_CH       = 2,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 1024,
  parameter int CNT_W      = 16
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  multi_cam_frame_sync_if.slave axis,
  output logic                 locked,
  output logic [CNT_W-1:0]     frame_cnt,
  output logic [CNT_W-1:0]     err_cnt,
  output logic [CNT_W-1:0]     drop_cnt
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int PC_W = $clog2(N_CH + 1);
  localparam int CW1  = CNT_W + 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic {SEEK, STREAM} state_t;

  state_t                   state_q, state_d;
  logic [N_CH-1:0]          ne, head_user, head_last, pop, seek_pop;
  logic [N_CH*DATA_W-1:0]   head_data;
  logic                     all_ne, all_sof, flags_match, slot_free, load, desync;

  logic                     tvalid_q, tvalid_d;
  logic                     tuser_q, tuser_d, tlast_q, tlast_d;
  logic [N_CH*DATA_W-1:0]   tdata_q, tdata_d;
  logic [CNT_W-1:0]         frame_q, frame_d, err_q, err_d, drop_q, drop_d;
  logic [PC_W-1:0]          drop_inc;
  logic [CNT_W:0]           drop_sum;

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_fifo
      logic [DATA_W+1:0] mem [FIFO_DEPTH];
      logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
      logic [AW:0]       fill_q;
      logic              tready_w, wr_en;

      // Ready comes only from the registered fill, so a pop never frees a
      // slot for a same-cycle write into a full FIFO.
      assign tready_w = aresetn & (fill_q < FULL_CNT);
      assign wr_en    = axis.s_axis_tvalid[gi] & tready_w;
      assign axis.s_axis_tready[gi] = tready_w;

      always_ff @(posedge aclk) begin
        if (wr_en)
          mem[wr_ptr_q] <= {axis.s_axis_tuser[gi], axis.s_axis_tlast[gi],
                            axis.s_axis_tdata[gi*DATA_W +: DATA_W]};
      end

      always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
          wr_ptr_q <= '0;
          rd_ptr_q <= '0;
          fill_q   <= '0;
        end else begin
          if (wr_en)   wr_ptr_q <= wr_ptr_q + AW'(1);
          if (pop[gi]) rd_ptr_q <= rd_ptr_q + AW'(1);
          if (wr_en && !pop[gi])      fill_q <= fill_q + (AW+1)'(1);
          else if (!wr_en && pop[gi]) fill_q <= fill_q - (AW+1)'(1);
        end
      end

      // Head is read straight from the array so it is visible the cycle after the write.
      assign ne[gi] = (fill_q != '0);
      assign {head_user[gi], head_last[gi], head_data[gi*DATA_W +: DATA_W]} = mem[rd_ptr_q];
    end
  endgenerate

  assign all_ne      = &ne;
  assign all_sof     = all_ne & (&head_user);
  assign flags_match = ((&head_user) | ~(|head_user)) & ((&head_last) | ~(|head_last));
  assign slot_free   = ~tvalid_q | axis.m_axis_tready;

  always_comb begin
    state_d  = state_q;
    pop      = '0;
    seek_pop = '0;
    load     = 1'b0;
    desync   = 1'b0;
    case (state_q)
      SEEK: begin
        // Drain mid-frame words; lanes already parked on SOF wait for the rest.
        seek_pop = ne & ~head_user;
        pop      = seek_pop;
        if (all_sof) state_d = STREAM;
      end
      STREAM: begin
        if (all_ne && slot_free) begin
          if (flags_match) begin
            pop  = '1;
            load = 1'b1;
          end else begin
            desync  = 1'b1;
            state_d = SEEK;
          end
        end
      end
      default: state_d = SEEK;
    endcase
  end

  always_comb begin
    drop_inc = '0;
    for (int i = 0; i < N_CH; i++) drop_inc = drop_inc + PC_W'(seek_pop[i]);
  end

  assign drop_sum = {1'b0, drop_q} + CW1'(drop_inc);

  always_comb begin
    tvalid_d = load | (tvalid_q & ~axis.m_axis_tready);
    tdata_d  = load ? head_data    : tdata_q;
    tuser_d  = load ? head_user[0] : tuser_q;
    tlast_d  = load ? head_last[0] : tlast_q;
    frame_d  = (load && head_user[0]) ? frame_q + CNT_W'(1) : frame_q;
    err_d    = (desync && err_q != '1) ? err_q + CNT_W'(1) : err_q;
    drop_d   = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q  <= SEEK;
      tvalid_q <= 1'b0;
      tuser_q  <= 1'b0;
      tlast_q  <= 1'b0;
      tdata_q  <= '0;
      frame_q  <= '0;
      err_q    <= '0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      tvalid_q <= tvalid_d;
      tuser_q  <= tuser_d;
      tlast_q  <= tlast_d;
      tdata_q  <= tdata_d;
      frame_q  <= frame_d;
      err_q    <= err_d;
      drop_q   <= drop_d;
    end
  end

  assign axis.m_axis_tvalid = tvalid_q;
  assign axis.m_axis_tdata  = tdata_q;
  assign axis.m_axis_tuser  = tuser_q;
  assign axis.m_axis_tlast  = tlast_q;
  assign axis.m_axis_tkeep  = '1;

  assign locked    = (state_q == STREAM);
  assign frame_cnt = frame_q;
  assign err_cnt   = err_q;
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_multi_cam_frame_sync.sv
// Scoreboard bench for multi_cam_frame_sync: directed frames go in per-lane
// queues, expected packed beats into exp_q, and a monitor pops and compares.
module tb_multi_cam_frame_sync;
  localparam int N_CH       = 2;
  localparam int DATA_W     = 32;
  localparam int FIFO_DEPTH = 4;
  localparam int CNT_W      = 4;

  typedef logic [DATA_W+1:0]      word_t;
  typedef logic [N_CH*DATA_W+1:0] beat_t;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  logic locked;
  logic [CNT_W-1:0] frame_cnt, err_cnt, drop_cnt;

  always #5 aclk = ~aclk;

  multi_cam_frame_sync_if #(.N_CH(N_CH), .DATA_W(DATA_W)) bus ();

  multi_cam_frame_sync #(
    .N_CH(N_CH), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .axis(bus), .locked(locked),
    .frame_cnt(frame_cnt), .err_cnt(err_cnt), .drop_cnt(drop_cnt)
  );

  word_t src_q [N_CH][$];
  beat_t exp_q [$];
  int    n_vec = 0;
  int    n_bad = 0;
  int    cyc = 0;
  bit    lat_arm = 0;
  int    first_wr [N_CH];
  int    first_vld = -1;
  bit    bp_mode = 0;
  bit    bp_seen = 0;

  always @(posedge aclk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] pix(input int c, input int f, input int p, input bit same);
    logic [7:0] cb;
    cb = same ? 8'h00 : 8'(8'hA0 + c);
    return {cb, 8'(f), 16'(p)};
  endfunction

  // Pixels lo..hi of an 8x4 frame on both lanes; beats with p < exp_hi are expected.
  // early >= 0 moves lane 0's first tlast to that pixel.
  task automatic send_range(input int f, input int lo, input int hi, input int exp_hi,
                            input int early, input bit same);
    for (int p = lo; p <= hi; p++) begin
      logic u, l0, l1;
      logic [31:0] d0, d1;
      u  = (p == 0);
      l1 = ((p % 8) == 7);
      l0 = l1;
      if (early >= 0) begin
        if (p == early) l0 = 1'b1;
        else if (p == early + 1) l0 = 1'b0;
      end
      d0 = pix(0, f, p, same);
      d1 = pix(1, f, p, same);
      src_q[0].push_back({u, l0, d0});
      src_q[1].push_back({u, l1, d1});
      if (p < exp_hi) exp_q.push_back({u, l0, d1, d0});
    end
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((src_q[0].size() != 0 || src_q[1].size() != 0 || bus.s_axis_tvalid != '0 ||
            exp_q.size() != 0 || bus.m_axis_tvalid) && n < 3000) begin
      @(negedge aclk);
      n++;
    end
    repeat (10) @(negedge aclk);
    if (n >= 3000) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s_timeout: %0d beats still expected, want 0", tag, exp_q.size());
      src_q[0].delete();
      src_q[1].delete();
      exp_q.delete();
    end
  endtask

  task automatic reset_pulse();
    @(negedge aclk);
    aresetn = 1'b0;
    #1;
    check("rst_tvalid", bus.m_axis_tvalid, 0);
    check("rst_tuser",  bus.m_axis_tuser, 0);
    check("rst_tlast",  bus.m_axis_tlast, 0);
    check("rst_tdata",  bus.m_axis_tdata, 0);
    check("rst_locked", locked, 0);
    check("rst_frame",  frame_cnt, 0);
    check("rst_err",    err_cnt, 0);
    check("rst_drop",   drop_cnt, 0);
    check("rst_sready", bus.s_axis_tready, 0);
    repeat (3) @(negedge aclk);
    check("rst_hold", {bus.m_axis_tvalid, locked, frame_cnt, err_cnt, drop_cnt, bus.s_axis_tready}, 0);
    aresetn = 1'b1;
  endtask

  // Lane drivers: hold each word until its handshake completes.
  initial begin
    bit hs [N_CH];
    word_t w;
    bus.s_axis_tvalid = '0;
    bus.s_axis_tdata  = '0;
    bus.s_axis_tuser  = '0;
    bus.s_axis_tlast  = '0;
    forever begin
      @(negedge aclk);
      for (int c = 0; c < N_CH; c++) begin
        hs[c] = bus.s_axis_tvalid[c] & bus.s_axis_tready[c];
        if (hs[c] && lat_arm && first_wr[c] < 0) first_wr[c] = cyc + 1;
      end
      @(posedge aclk);
      #1;
      for (int c = 0; c < N_CH; c++) begin
        if (hs[c]) bus.s_axis_tvalid[c] = 1'b0;
        if (!bus.s_axis_tvalid[c] && src_q[c].size() != 0) begin
          w = src_q[c].pop_front();
          bus.s_axis_tdata[c*DATA_W +: DATA_W] = w[DATA_W-1:0];
          bus.s_axis_tuser[c]  = w[DATA_W+1];
          bus.s_axis_tlast[c]  = w[DATA_W];
          bus.s_axis_tvalid[c] = 1'b1;
        end
      end
    end
  end

  // Output ready: always on, or 1 cycle on / 3 off in backpressure mode.
  initial begin
    bus.m_axis_tready = 1'b1;
    forever begin
      @(posedge aclk);
      #1;
      bus.m_axis_tready = bp_mode ? ((cyc % 4) == 0) : 1'b1;
    end
  end

  // Monitor: compares every accepted beat against the scoreboard head.
  initial begin
    beat_t cur, prev, e;
    bit prev_stall;
    prev_stall = 0;
    prev = '0;
    forever begin
      @(negedge aclk);
      cur = {bus.m_axis_tuser, bus.m_axis_tlast, bus.m_axis_tdata};
      if (!aresetn) begin
        prev_stall = 0;
      end else begin
        if (lat_arm && first_vld < 0 && bus.m_axis_tvalid) first_vld = cyc;
        if (bp_mode && bus.s_axis_tready != '1) bp_seen = 1;
        if (bus.m_axis_tvalid && prev_stall) check("stall_hold", cur, prev);
        if (bus.m_axis_tvalid && bus.m_axis_tready) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL extra_beat: got %0h, want no beat", cur);
          end else begin
            e = exp_q.pop_front();
            check("beat", cur, e);
          end
        end
        prev_stall = bus.m_axis_tvalid & ~bus.m_axis_tready;
        prev = cur;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat_ref;
    for (int c = 0; c < N_CH; c++) first_wr[c] = -1;

    // Aligned start, identical lanes
    reset_pulse();
    first_vld = -1;
    lat_arm = 1;
    send_range(1, 0, 31, 32, -1, 1);
    wait_idle("aligned");
    lat_arm = 0;
    lat_ref = (first_wr[0] > first_wr[1]) ? first_wr[0] : first_wr[1];
    check("aligned_latency", first_vld - lat_ref, 2);
    check("aligned_frame", frame_cnt, 1);
    check("aligned_locked", locked, 1);
    check("aligned_err", err_cnt, 0);
    check("aligned_drop", drop_cnt, 0);
    check("tkeep", bus.m_axis_tkeep, 8'hFF);
    $display("aligned: %0d vectors so far", n_vec);

    // Skewed start: 5 junk words on lane 1
    reset_pulse();
    for (int k = 0; k < 5; k++) src_q[1].push_back({2'b00, 32'hBAD0_0000 | 32'(k)});
    send_range(2, 0, 31, 32, -1, 0);
    wait_idle("skewed");
    check("skew_drop", drop_cnt, 5);
    check("skew_err", err_cnt, 0);
    check("skew_frame", frame_cnt, 1);
    $display("skewed: %0d vectors so far", n_vec);

    // Desync: lane 0 tlast early at beat 6, then a clean frame
    reset_pulse();
    send_range(3, 0, 31, 6, 6, 0);
    wait_idle("desync");
    check("desync_err", err_cnt, 1);
    check("desync_locked", locked, 0);
    check("desync_frame", frame_cnt, 1);
    send_range(4, 0, 31, 32, -1, 0);
    wait_idle("relock");
    check("relock_frame", frame_cnt, 2);
    check("relock_locked", locked, 1);
    check("relock_err", err_cnt, 1);
    check("relock_drop", drop_cnt, 15);
    $display("desync: %0d vectors so far", n_vec);

    // Backpressure: ready 1 on / 3 off, two continuous frames
    reset_pulse();
    bp_seen = 0;
    bp_mode = 1;
    send_range(5, 0, 31, 32, -1, 0);
    send_range(6, 0, 31, 32, -1, 0);
    wait_idle("backpressure");
    bp_mode = 0;
    check("bp_sready_low", bp_seen, 1);
    check("bp_frame", frame_cnt, 2);
    check("bp_err", err_cnt, 0);
    $display("backpressure: %0d vectors so far", n_vec);

    // Reset mid-frame: 10 pixels out, reset, remainder dropped, next frame intact
    reset_pulse();
    send_range(7, 0, 9, 10, -1, 0);
    wait_idle("partial");
    check("partial_locked", locked, 1);
    check("partial_frame", frame_cnt, 1);
    reset_pulse();
    send_range(7, 10, 31, 0, -1, 0);
    send_range(8, 0, 31, 32, -1, 0);
    wait_idle("post_reset");
    check("postrst_frame", frame_cnt, 1);
    check("postrst_drop", drop_cnt, 15);
    check("postrst_err", err_cnt, 0);
    $display("reset mid-frame: %0d vectors so far", n_vec);

    // Saturation: 20 SOF beats each followed by a tlast mismatch
    reset_pulse();
    for (int e = 0; e < 20; e++) begin
      logic [31:0] d0, d1;
      d0 = pix(0, 9, e, 0);
      d1 = pix(1, 9, e, 0);
      src_q[0].push_back({2'b10, d0});
      src_q[1].push_back({2'b10, d1});
      exp_q.push_back({2'b10, d1, d0});
      src_q[0].push_back({2'b01, d0 ^ 32'hFFFF});
      src_q[1].push_back({2'b00, d1 ^ 32'hFFFF});
    end
    wait_idle("saturation");
    check("sat_err", err_cnt, 15);
    check("sat_frame_wrap", frame_cnt, 4);
    check("sat_drop", drop_cnt, 15);
    check("sat_locked", locked, 0);
    $display("saturation: %0d vectors so far", n_vec);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
